// File: rtl/chi_stage_pkg.sv
// Shared definitions for the Keccak chi / round-constant slice stages.
// Holds state encoding and slice geometry.
package chi_stage_pkg;

  localparam int CHI_W          = 25;
  localparam int CHI_NUM_SLICES = 64;
  localparam int CHI_AW         = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } chi_state_e;

endpackage

// File: rtl/chi_stage_if.sv
// Control and slice-memory bus of the chi stage.
// master: controller/memories, slave: chi_stage.
interface chi_stage_if #(
  parameter int W  = chi_stage_pkg::CHI_W,
  parameter int AW = chi_stage_pkg::CHI_AW
) ();

  logic          start;
  logic          busy;
  logic          done;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [W-1:0]  in_rd_data;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [W-1:0]  out_wr_data;

  modport master (
    output start,
    output in_rd_data,
    input  busy,
    input  done,
    input  in_rd_en,
    input  in_rd_addr,
    input  out_wr_en,
    input  out_wr_addr,
    input  out_wr_data
  );

  modport slave (
    input  start,
    input  in_rd_data,
    output busy,
    output done,
    output in_rd_en,
    output in_rd_addr,
    output out_wr_en,
    output out_wr_addr,
    output out_wr_data
  );

endinterface

// File: rtl/chi_stage_slice_counter.sv
// Slice index counter: clear, enable, terminal-count flag.
// Saturates at NUM-1 so the index never wraps within a run.
module slice_counter #(
  parameter int AW  = 6,
  parameter int NUM = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_cnt,
  output logic          o_tc
);

  logic [AW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc  = (r_cnt == AW'(NUM - 1));
  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chi_stage.sv
// Keccak chi step over a slice memory, one slice per three cycles.
// Read, capture, write back chi(slice) for every slice index.
module chi_stage
  import chi_stage_pkg::*;
#(
  parameter int W          = CHI_W,
  parameter int NUM_SLICES = CHI_NUM_SLICES,
  parameter int AW         = CHI_AW
) (
  input  logic       clk,
  input  logic       rst,
  chi_stage_if.slave bus
);

  chi_state_e    r_state;
  chi_state_e    w_next;
  logic [W-1:0]  r_slice;
  logic [W-1:0]  w_chi;
  logic [AW-1:0] w_idx;
  logic          w_tc;
  logic          w_cnt_en;
  logic          w_cnt_clr;

  slice_counter #(
    .AW  (AW),
    .NUM (NUM_SLICES)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_idx),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = bus.start ? S_READ : S_IDLE;
      S_READ:  w_next = S_CALC;
      S_CALC:  w_next = S_WRITE;
      S_WRITE: w_next = w_tc ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // read data is valid during CALC, one cycle after the strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slice <= '0;
    end else if (r_state == S_CALC) begin
      r_slice <= bus.in_rd_data;
    end
  end

  // r_slice only moves on CALC->WRITE, so write data holds elsewhere
  always_comb begin
    w_chi = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        w_chi[5*y+x] = r_slice[5*y+x] ^
                       (~r_slice[5*y+((x+1)%5)] &
                         r_slice[5*y+((x+2)%5)]);
      end
    end
  end

  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_DONE);
    bus.in_rd_en  = (r_state == S_READ);
    bus.out_wr_en = (r_state == S_WRITE);
    w_cnt_en      = (r_state == S_WRITE);
    w_cnt_clr     = (r_state == S_DONE);
  end

  assign bus.in_rd_addr  = w_idx;
  assign bus.out_wr_addr = w_idx;
  assign bus.out_wr_data = w_chi;

endmodule

// File: tb/tb_chi_stage.sv
// Randomized bench for chi_stage against a lane-array chi model.
// Memory model serves reads; writes are committed on the clock edge.
module tb_chi_stage;
  import chi_stage_pkg::*;

  localparam int W  = CHI_W;
  localparam int N  = CHI_NUM_SLICES;
  localparam int AW = CHI_AW;

  logic clk;
  logic rst;

  chi_stage_if #(.W(W), .AW(AW)) bus ();

  chi_stage #(
    .W          (W),
    .NUM_SLICES (N),
    .AW         (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  mem [N];
  logic [AW-1:0] wa [$];
  logic [W-1:0]  wd [$];
  int            checks;
  int            fails;
  int            dcnt;
  int            ovl;
  logic          s_en;
  logic [AW-1:0] s_a;
  logic [W-1:0]  s_d;

  always @(posedge clk)
    if (bus.in_rd_en) bus.in_rd_data <= mem[bus.in_rd_addr];

  always @(negedge clk) begin
    if (bus.in_rd_en && bus.out_wr_en) ovl++;
    if (bus.done) dcnt++;
    s_en = bus.out_wr_en;
    s_a  = bus.out_wr_addr;
    s_d  = bus.out_wr_data;
  end

  always @(posedge clk)
    if (rst && s_en) begin
      wa.push_back(s_a);
      wd.push_back(s_d);
    end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_chi(input logic [W-1:0] s);
    logic a [5][5];
    logic [W-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        a[x][y] = s[5*y+x];
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = a[x][y] ^ (!a[(x+1)%5][y] && a[(x+2)%5][y]);
    return r;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       mem[i] = '0;
        1:       mem[i] = (i == 5) ? W'(1) : '0;
        2:       mem[i] = (i == 0) ? W'(2) : (i == N-1) ? '1 : '0;
        default: mem[i] = W'($urandom);
      endcase
    end
  endtask

  task automatic run_test(input bit repulse, output int base);
    int n;
    int d0;
    int w0;
    d0 = dcnt;
    w0 = wa.size();
    base = w0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!bus.done && n < 400) begin
      bus.start = repulse && (n == 10 || n == 100);
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("done_cycle", n, 193);
    repeat (3) @(negedge clk);
    chk("done_pulses", dcnt - d0, 1);
    chk("wr_count", wa.size() - w0, N);
    chk("busy_after", bus.busy, 0);
    for (int i = 0; i < N && w0 + i < wa.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa[w0+i], i);
      chk($sformatf("wr_data[%0d]", i), wd[w0+i], ref_chi(mem[i]));
    end
  endtask

  task automatic chk_zero_outs(input string pfx);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_done"}, bus.done, 0);
    chk({pfx, "_rd_en"}, bus.in_rd_en, 0);
    chk({pfx, "_wr_en"}, bus.out_wr_en, 0);
    chk({pfx, "_rd_addr"}, bus.in_rd_addr, 0);
    chk({pfx, "_wr_addr"}, bus.out_wr_addr, 0);
    chk({pfx, "_wr_data"}, bus.out_wr_data, 0);
  endtask

  initial begin
    int b;
    int n;
    int w0;
    checks = 0;
    fails  = 0;
    dcnt   = 0;
    ovl    = 0;
    s_en   = 1'b0;
    s_a    = '0;
    s_d    = '0;
    rst    = 1'b0;
    bus.start = 1'b0;
    bus.in_rd_data = '0;
    fill(0);
    #1;
    chk_zero_outs("reset");
    #21;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    fill(0);
    run_test(1'b0, b);
    fill(1);
    run_test(1'b0, b);
    if (wd.size() > b + 5) chk("slice5", wd[b+5], 32'h0000009);
    else chk("slice5_present", wd.size(), b + 6);
    fill(2);
    run_test(1'b0, b);
    if (wd.size() >= b + N) begin
      chk("slice0", wd[b], 32'h0000012);
      chk("slice63", wd[b+N-1], 32'h1FFFFFF);
    end else chk("term_present", wd.size(), b + N);
    fill(3);
    run_test(1'b0, b);
    fill(3);
    run_test(1'b1, b);

    fill(3);
    w0 = wa.size();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.out_wr_en && bus.out_wr_addr == 20) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wr20_reached", n < 400, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_outs("midrst");
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_wrs", wa.size() - w0, 20);
    chk("midrst_idle", bus.busy, 0);
    run_test(1'b0, b);

    chk("rd_wr_overlap", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
